fnd_scan_capture: RTL and testbench

- Receive-side counterpart of the FND font/digit-select drive path.
- Samples a multiplexed 4-digit, 7-segment bus (active-low digit enables plus active-low segment font), waits out ghosting and settling, and decodes each font back to a 4-bit hex value.
- Reassembles a full 16-bit display word.
- Used for loopback self-check of the display path and for on-board capture of FND traffic.

---
 rtl/fnd_pkg.sv | 27 ++
 rtl/fnd_font_to_hex.sv | 25 ++
 rtl/fnd_scan_capture.sv | 166 ++++++++++++++++
 tb/tb_fnd_scan_capture.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the FND capture path.
// Holds the active-low 7-segment font table for hex 0..F (indexed by value),
// digit slot indices, and the scan-capture FSM state type.
package fnd_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;

  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;
  localparam logic [1:0] DIG3 = 2'd3;

  // Segment patterns {g,f,e,d,c,b,a}, active-low; entry i encodes hex digit i.
  localparam logic [15:0][SEG_W-1:0] FONT_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/fnd_font_to_hex.sv
// Combinational reverse lookup of an active-low 7-segment font.
// Ports: seg   - segments {g,f,e,d,c,b,a}, active-low
//        value - decoded hex nibble (0 when not recognised)
//        valid - high when seg matches one of the 16 table entries
module fnd_font_to_hex
  import fnd_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] value,
  output logic             valid
);

  // Table entries are unique, so at most one iteration can hit.
  always_comb begin
    value = '0;
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == FONT_TABLE[i]) begin
        value = NIB_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fnd_scan_capture.sv
// Receive side of a multiplexed 4-digit 7-segment bus: waits for a digit/font
// pair to be stable for STABLE_CYCLES samples, decodes the font back to hex and
// reassembles a 16-bit display word.
// Optional build macro: FND_SCAN_DP_CAPTURE_EN adds o_dp (per-digit dp, active-high).
// Ports: i_clk, i_reset (sync, active-high)
//        i_digit       - active-low one-hot digit enable, bit0 = least-significant
//        i_font        - active-low segments {dp,g,f,e,d,c,b,a}
//        o_value       - last complete frame {d3,d2,d1,d0}
//        o_frame_valid - one-cycle pulse when o_value updates
//        o_err         - one-cycle pulse on a stable but undecodable font
//        o_seen        - digits captured in the current partial frame
module fnd_scan_capture
  import fnd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_digit,
  input  logic [7:0]  i_font,
  output logic [15:0] o_value,
  output logic        o_frame_valid,
  output logic        o_err,
  output logic [3:0]  o_seen
`ifdef FND_SCAN_DP_CAPTURE_EN
  ,
  output logic [3:0]  o_dp
`endif
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic             STABLE_ONE = (STABLE_CYCLES == 1);

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [CNT_W-1:0]               cnt_inc;
  logic [3:0]                     smp_digit;
  logic [7:0]                     smp_font;
  logic [DIGITS-1:0][NIB_W-1:0]   slots;
  logic                           publish;
  logic                           legal;
  logic                           changed;
  logic [1:0]                     dig_idx;
  logic                           capture;
  logic [NIB_W-1:0]               dec_val;
  logic                           dec_ok;
  logic [3:0]                     seen_next;
`ifdef FND_SCAN_DP_CAPTURE_EN
  logic [DIGITS-1:0]              dp_slots;
`endif

  fnd_font_to_hex u_dec (
    .seg   (i_font[SEG_W-1:0]),
    .value (dec_val),
    .valid (dec_ok)
  );

  assign cnt_inc = cnt + CNT_W'(1);
  assign changed = ({i_digit, i_font} != {smp_digit, smp_font});

  // Exactly one low bit selects a slot; anything else counts as blanking.
  always_comb begin
    legal   = 1'b1;
    dig_idx = DIG0;
    unique case (i_digit)
      4'b1110: dig_idx = DIG0;
      4'b1101: dig_idx = DIG1;
      4'b1011: dig_idx = DIG2;
      4'b0111: dig_idx = DIG3;
      default: legal = 1'b0;
    endcase
  end

  // Capture fires on the edge that completes the required run of identical
  // samples; a fresh legal pattern already counts as the first sample.
  always_comb begin
    capture = 1'b0;
    unique case (state)
      IDLE:    capture = legal && STABLE_ONE;
      SETTLE:  capture = legal && (changed ? STABLE_ONE : (cnt_inc == STABLE_CNT));
      HOLD:    capture = legal && changed && STABLE_ONE;
      default: capture = 1'b0;
    endcase
  end

  // A publish clears the partial frame before any same-cycle capture lands.
  always_comb begin
    seen_next = publish ? 4'b0000 : o_seen;
    if (capture && dec_ok) seen_next[dig_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      smp_digit     <= '0;
      smp_font      <= '0;
      slots         <= '0;
      publish       <= 1'b0;
      o_value       <= '0;
      o_frame_valid <= 1'b0;
      o_err         <= 1'b0;
      o_seen        <= '0;
`ifdef FND_SCAN_DP_CAPTURE_EN
      dp_slots      <= '0;
      o_dp          <= '0;
`endif
    end else begin
      smp_digit     <= i_digit;
      smp_font      <= i_font;
      o_frame_valid <= publish;
      o_err         <= capture && !dec_ok;
      o_seen        <= seen_next;
      publish       <= capture && dec_ok && (seen_next == 4'b1111);

      if (publish) begin
        o_value <= slots;
`ifdef FND_SCAN_DP_CAPTURE_EN
        o_dp    <= dp_slots;
`endif
      end

      if (capture && dec_ok) begin
        slots[dig_idx]    <= dec_val;
`ifdef FND_SCAN_DP_CAPTURE_EN
        dp_slots[dig_idx] <= ~i_font[7];
`endif
      end

      unique case (state)
        IDLE: begin
          if (legal) begin
            cnt   <= CNT_W'(1);
            state <= capture ? HOLD : SETTLE;
          end
        end
        SETTLE: begin
          if (!legal) begin
            state <= IDLE;
          end else if (changed) begin
            cnt   <= CNT_W'(1);
            state <= capture ? HOLD : SETTLE;
          end else if (capture) begin
            state <= HOLD;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HOLD: begin
          // Stay put for the rest of the dwell; only a change re-arms capture.
          if (changed) begin
            if (!legal) begin
              state <= IDLE;
            end else begin
              cnt   <= CNT_W'(1);
              state <= capture ? HOLD : SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_capture.sv
// Scoreboard bench for fnd_scan_capture: stimulus is a list of dwells (a
// digit/font pair held for N cycles); a dwell-level model predicts frame and
// error events, and a monitor compares them as the DUT pulses its outputs.
module tb_fnd_scan_capture;

  localparam int unsigned STABLE = 4;

  typedef struct packed {
    logic        is_frame;
    logic [15:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digit;
  logic [7:0]  font;
  logic [15:0] value;
  logic        frame_valid;
  logic        err;
  logic [3:0]  seen;
`ifdef FND_SCAN_DP_CAPTURE_EN
  logic [3:0]  dp;
`endif

  int errors = 0;
  int checks = 0;

  exp_t       exp_q[$];
  logic [3:0] m_slot[4];
  logic [3:0] m_seen;
  logic [6:0] font_tab[16];

  always #5 clk = ~clk;

  fnd_scan_capture #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_digit       (digit),
    .i_font        (font),
    .o_value       (value),
    .o_frame_valid (frame_valid),
    .o_err         (err),
    .o_seen        (seen)
`ifdef FND_SCAN_DP_CAPTURE_EN
    ,
    .o_dp          (dp)
`endif
  );

  function automatic int decode(input logic [7:0] f);
    for (int i = 0; i < 16; i++) if (f[6:0] == font_tab[i]) return i;
    return -1;
  endfunction

  function automatic int slot_of(input logic [3:0] d);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < 4; i++) if (!d[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
    m_seen = 4'b0000;
  endtask

  // A dwell of a legal digit lasting at least STABLE cycles captures exactly once.
  task automatic model_dwell(input logic [3:0] d, input logic [7:0] f, input int n);
    int idx;
    int v;
    exp_t e;
    idx = slot_of(d);
    if (idx < 0 || n < int'(STABLE)) return;
    v = decode(f);
    if (v < 0) begin
      e.is_frame = 1'b0;
      e.value    = 16'h0000;
      exp_q.push_back(e);
    end else begin
      m_slot[idx] = 4'(v);
      m_seen[idx] = 1'b1;
      if (m_seen == 4'b1111) begin
        e.is_frame = 1'b1;
        e.value    = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        exp_q.push_back(e);
        m_seen = 4'b0000;
      end
    end
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] f, input int n);
    model_dwell(d, f, n);
    digit = d;
    font  = f;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic blank(input int n);
    hold(4'b1111, 8'hFF, n);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    digit = 4'b1111;
    font  = 8'hFF;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: every output pulse must match the oldest predicted event.
  always @(negedge clk) begin
    if (!reset && (frame_valid || err)) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: frame_valid=%b err=%b value=%h, none expected", frame_valid, err, value);
      end else begin
        e = exp_q.pop_front();
        if (e.is_frame) begin
          if (!frame_valid || err || value !== e.value) begin
            errors++;
            $display("FAIL frame: frame_valid=%b err=%b value=%h expected frame value=%h", frame_valid, err, value, e.value);
          end
        end else if (!err || frame_valid) begin
          errors++;
          $display("FAIL err_pulse: frame_valid=%b err=%b expected err only", frame_valid, err);
        end
      end
    end
  end

  initial begin
    logic [3:0] pd;
    logic [7:0] pf;
    logic [3:0] d;
    logic [7:0] f;
    int         n;

    font_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    model_reset();
    do_reset();
    check("reset_value", value, 16'h0000);
    check("reset_seen", 16'(seen), 16'h0000);
    check("reset_frame_valid", 16'(frame_valid), 16'h0000);
    check("reset_err", 16'(err), 16'h0000);

    // Basic scan 0,1,2,3.
    hold(4'b1110, 8'hC0, 4);
    hold(4'b1101, 8'hF9, 4);
    hold(4'b1011, 8'hA4, 4);
    hold(4'b0111, 8'hB0, 4);
    blank(4);
    check("scan_value", value, 16'h3210);
    check("scan_seen_cleared", 16'(seen), 16'h0000);

    // One cycle short of stable.
    hold(4'b1110, 8'hC0, 3);
    blank(3);
    check("short_dwell_seen", 16'(seen), 16'(m_seen));

    // Stable but undecodable font.
    hold(4'b1110, 8'hFF, 4);
    blank(3);
    check("bad_font_seen", 16'(seen), 16'(m_seen));

    // Overwrite of digit0: 5 then A, then 7/E/F.
    hold(4'b1110, 8'h92, 4);
    hold(4'b1110, 8'h88, 4);
    hold(4'b1101, 8'hF8, 4);
    hold(4'b1011, 8'h86, 4);
    hold(4'b0111, 8'h8E, 4);
    blank(4);
    check("overwrite_value", value, 16'hFE7A);

    // Long dwells capture once only.
    hold(4'b1110, 8'hC0, 20);
    blank(3);
    check("long_dwell_seen", 16'(seen), 16'(m_seen));
    hold(4'b1110, 8'hFF, 20);
    blank(3);
    check("long_bad_seen", 16'(seen), 16'(m_seen));

    // Two digits low is blanking.
    hold(4'b1100, 8'hF9, 8);
    blank(3);
    check("multi_low_seen", 16'(seen), 16'(m_seen));

    // Reset with a partial frame pending.
    hold(4'b1101, 8'hC0, 4);
    blank(3);
    check("partial_seen", 16'(seen), 16'b0011);
    do_reset();
    check("midreset_seen", 16'(seen), 16'h0000);
    check("midreset_value", value, 16'h0000);
    hold(4'b1110, 8'h80, 4);
    hold(4'b1101, 8'h90, 4);
    hold(4'b1011, 8'h88, 4);
    hold(4'b0111, 8'h83, 4);
    blank(4);
    check("post_reset_value", value, 16'hBA98);

    // Randomised dwells; consecutive dwells are kept distinct.
    pd = 4'b1111;
    pf = 8'hFF;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    d = 4'b1111;
        2, 3:    d = 4'($urandom);
        default: d = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 3) != 0) f = {1'($urandom), font_tab[$urandom_range(0, 15)]};
      else f = 8'($urandom);
      if (d == pd && f == pf) f = f ^ 8'h80;
      n = $urandom_range(1, 8);
      hold(d, f, n);
      pd = d;
      pf = f;
    end
    blank(4);
    check("random_seen", 16'(seen), 16'(m_seen));

    blank(10);
    check("pending_events", 16'(exp_q.size()), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
